// File: rtl/spi_cfg_master_if.sv
// -----------------------------------------------------------------------------
// spi_cfg_master_if
//   Command interface between the two internal requesters and spi_cfg_master.
//
//   Handshake: a requester raises reqN_valid with reqN_addr/reqN_data stable
//   and keeps all three stable until the cycle in which reqN_valid && reqN_ready
//   are both high at a rising clk edge; that edge is the accept. reqN_ready is
//   combinational and may depend on reqN_valid. Payload is sampled only at the
//   accept edge.
//
//   Signals (per requester N = 0, 1):
//     reqN_valid  requester -> master  write command pending
//     reqN_ready  master -> requester  command accepted on this edge if valid
//     reqN_addr   requester -> master  7-bit target register address
//     reqN_data   requester -> master  8-bit write data
//
//   Modports:
//     master : requester side (drives valid/addr/data)
//     slave  : spi_cfg_master side (drives ready)
// -----------------------------------------------------------------------------
interface spi_cfg_master_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;

  logic       req1_valid;
  logic       req1_ready;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/spi_cfg_master.sv
// -----------------------------------------------------------------------------
// spi_cfg_master
//   Writes the peripheral configuration registers over a 3-wire SPI link
//   (nCS/SCLK/COPI). Two requesters share the block through a round-robin
//   arbiter; each accepted command becomes one 16-bit frame:
//     bit15 = 1 (write), bits14:8 = addr, bits7:0 = data, sent MSB first.
//   Commands with addr > MAX_ADDR are dropped with a one-cycle err pulse and
//   never touch the bus.
//
//   Frame timing (H = CLK_DIV clk cycles):
//     SETUP H | 16 x SHIFT_HI H, with 15 SHIFT_LO H between them | HOLD H
//     then nCS high; GAP plus the following IDLE cycle give 2*H of nCS high
//     before the next frame can pull nCS low again.
//   CLK_DIV must be >= 4: the slave resynchronises SCLK/nCS through two flops
//   and an edge detector, so every level has to persist at least that long.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req        slave modport of spi_cfg_master_if (two valid/ready channels)
//   busy       out  frame or inter-frame gap in progress
//   done       out  one-cycle pulse on the cycle nCS returns high
//   err        out  one-cycle pulse after an out-of-range command is accepted
//   nCS        out  chip select, active low
//   SCLK       out  serial clock, idle low
//   COPI       out  serial data, changes only while SCLK is low
//   dbg_state  out  current FSM state encoding (state_t below)
// -----------------------------------------------------------------------------
module spi_cfg_master #(
  parameter int CLK_DIV  = 4,
  parameter int MAX_ADDR = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_cfg_master_if.slave        req,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   nCS,
  output logic                   SCLK,
  output logic                   COPI,
  output logic [2:0]             dbg_state
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);

  // Last cycle index of a CLK_DIV-long phase.
  localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_DIV - 1);
  // GAP occupies 2*CLK_DIV-1 cycles; the IDLE cycle that follows (where the
  // next command can be accepted) still has nCS high, completing 2*CLK_DIV.
  localparam logic [CW-1:0] GAP_LAST   = CW'(2 * CLK_DIV - 2);
  localparam logic [6:0]    ADDR_MAX   = 7'(MAX_ADDR);
  localparam logic [4:0]    LAST_BIT   = 5'd15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] phase_cnt, phase_cnt_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [15:0]   shreg, shreg_nx;
  logic          last, last_nx;   // 1: req1 was the most recent accept
  logic          busy_nx, done_nx, err_nx, ncs_nx, sclk_nx;

  logic          grant0, grant1;
  logic          accept;
  logic          sel1;
  logic [6:0]    sel_addr;
  logic [7:0]    sel_data;
  logic          phase_end;
  logic          gap_end;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone valid requester wins; on a tie the requester that was
  // not accepted last wins. Readies only exist in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = req.req0_valid && (!req.req1_valid || last);
    grant1 = req.req1_valid && (!req.req0_valid || !last);
  end

  assign req.req0_ready = (state == IDLE) && grant0;
  assign req.req1_ready = (state == IDLE) && grant1;

  assign accept   = (req.req0_valid && req.req0_ready) ||
                    (req.req1_valid && req.req1_ready);
  assign sel1     = grant1;
  assign sel_addr = sel1 ? req.req1_addr : req.req0_addr;
  assign sel_data = sel1 ? req.req1_data : req.req0_data;

  assign phase_end = (phase_cnt == PHASE_LAST);
  assign gap_end   = (phase_cnt == GAP_LAST);

  // COPI is the MSB of the shift register. Zeros are shifted in, so after the
  // sixteenth shift the register is empty and COPI rests at 0 for HOLD and
  // IDLE without a separate data path.
  assign COPI      = shreg[15];
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Every registered output is computed
  // here from the transition, so outputs change on the same edge as state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx     = state;
    phase_cnt_nx = phase_cnt;
    bit_cnt_nx   = bit_cnt;
    shreg_nx     = shreg;
    last_nx      = last;
    busy_nx      = busy;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
    ncs_nx       = nCS;
    sclk_nx      = SCLK;

    case (state)
      IDLE: begin
        if (accept) begin
          // Pointer moves on every accept, rejected commands included.
          last_nx = sel1;
          if (sel_addr > ADDR_MAX) begin
            err_nx = 1'b1;
          end else begin
            state_nx     = SETUP;
            phase_cnt_nx = '0;
            bit_cnt_nx   = '0;
            shreg_nx     = {1'b1, sel_addr, sel_data};
            ncs_nx       = 1'b0;
            sclk_nx      = 1'b0;
            busy_nx      = 1'b1;
          end
        end
      end

      SETUP: begin
        if (phase_end) begin
          state_nx     = SHIFT_HI;
          phase_cnt_nx = '0;
          sclk_nx      = 1'b1;
        end else begin
          phase_cnt_nx = phase_cnt + CW'(1);
        end
      end

      SHIFT_HI: begin
        if (phase_end) begin
          phase_cnt_nx = '0;
          bit_cnt_nx   = bit_cnt + 5'd1;
          sclk_nx      = 1'b0;
          // Next bit appears together with the falling SCLK edge.
          shreg_nx     = {shreg[14:0], 1'b0};
          if (bit_cnt == LAST_BIT) begin
            state_nx = HOLD;
          end else begin
            state_nx = SHIFT_LO;
          end
        end else begin
          phase_cnt_nx = phase_cnt + CW'(1);
        end
      end

      SHIFT_LO: begin
        if (phase_end) begin
          state_nx     = SHIFT_HI;
          phase_cnt_nx = '0;
          sclk_nx      = 1'b1;
        end else begin
          phase_cnt_nx = phase_cnt + CW'(1);
        end
      end

      HOLD: begin
        if (phase_end) begin
          state_nx     = GAP;
          phase_cnt_nx = '0;
          ncs_nx       = 1'b1;
          done_nx      = 1'b1;
        end else begin
          phase_cnt_nx = phase_cnt + CW'(1);
        end
      end

      GAP: begin
        if (gap_end) begin
          state_nx     = IDLE;
          phase_cnt_nx = '0;
          bit_cnt_nx   = '0;
          busy_nx      = 1'b0;
        end else begin
          phase_cnt_nx = phase_cnt + CW'(1);
        end
      end

      default: begin
        state_nx     = IDLE;
        phase_cnt_nx = '0;
        bit_cnt_nx   = '0;
        shreg_nx     = '0;
        busy_nx      = 1'b0;
        ncs_nx       = 1'b1;
        sclk_nx      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Reset drops any frame in flight: the bus
  // returns to idle immediately and no done is produced.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      last      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      nCS       <= 1'b1;
      SCLK      <= 1'b0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      last      <= last_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      nCS       <= ncs_nx;
      SCLK      <= sclk_nx;
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_spi_cfg_master
//   Directed bench for spi_cfg_master at CLK_DIV = 4, MAX_ADDR = 4.
//   A bus monitor decodes frames on nCS/SCLK/COPI into a model of the slave's
//   five registers and compares each frame against an expected queue.
// -----------------------------------------------------------------------------
module tb_spi_cfg_master;

  localparam int CLK_DIV = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  spi_cfg_master_if bus ();

  logic       busy, done, err, ncs, sclk, copi;
  logic [2:0] dbg_state;

  spi_cfg_master #(.CLK_DIV(CLK_DIV), .MAX_ADDR(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .nCS       (ncs),
    .SCLK      (sclk),
    .COPI      (copi),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Bus monitor, slave register model and frame scoreboard
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [15:0] exp_frame;
  logic [7:0]  slave_regs[0:4];
  logic        ncs_q, sclk_q, copi_q;
  logic [15:0] frame_bits;
  int          rises, low_cnt, gap_cnt, last_gap, frame_cnt, done_cnt, err_cnt;
  int          copi_viol, last_rise_cyc, last_copi_cyc, reg_idx;
  bit          seen_frame;

  initial begin
    for (int i = 0; i < 5; i++) slave_regs[i] = 8'h00;
    ncs_q = 1'b1; sclk_q = 1'b0; copi_q = 1'b0; frame_bits = '0;
    rises = 0; low_cnt = 0; gap_cnt = 0; last_gap = 0; frame_cnt = 0;
    done_cnt = 0; err_cnt = 0; copi_viol = 0; seen_frame = 0;
    last_rise_cyc = -100; last_copi_cyc = -100;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ncs_q = 1'b1; sclk_q = 1'b0; copi_q = 1'b0; frame_bits = '0;
      rises = 0; low_cnt = 0; gap_cnt = 0; seen_frame = 0;
      last_rise_cyc = -100; last_copi_cyc = -100;
    end else begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      // COPI may only move while SCLK is low and a full half-period after a rise.
      if (copi !== copi_q) begin
        if (sclk !== 1'b0 || cyc - last_rise_cyc < CLK_DIV) copi_viol++;
        last_copi_cyc = cyc;
      end
      if (sclk && !sclk_q) begin
        if (ncs !== 1'b0 || cyc - last_copi_cyc < CLK_DIV) copi_viol++;
        rises++;
        frame_bits    = {frame_bits[14:0], copi};
        last_rise_cyc = cyc;
      end
      if (!ncs) begin
        if (ncs_q && seen_frame) last_gap = gap_cnt;
        low_cnt++;
      end else if (!ncs_q) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL frame_done_at_ncs_rise: got %b, expected 1", done);
        end
        checks++;
        if (low_cnt != 33 * CLK_DIV) begin
          errors++;
          $display("FAIL frame_ncs_low_cycles: got %0d, expected %0d", low_cnt, 33 * CLK_DIV);
        end
        checks++;
        if (rises != 16) begin
          errors++;
          $display("FAIL frame_sclk_rises: got %0d, expected 16", rises);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got %h, expected no frame", frame_bits);
        end else begin
          exp_frame = exp_q.pop_front();
          if (frame_bits !== exp_frame) begin
            errors++;
            $display("FAIL frame_bits: got %h, expected %h", frame_bits, exp_frame);
          end
        end
        if (frame_bits[15] && frame_bits[14:8] <= 7'd4) begin
          reg_idx = int'(frame_bits[14:8]);
          slave_regs[reg_idx] = frame_bits[7:0];
        end
        frame_cnt++;
        seen_frame = 1;
        gap_cnt    = 1;
        rises      = 0;
        low_cnt    = 0;
        frame_bits = '0;
      end else begin
        gap_cnt++;
      end
      ncs_q  = ncs;
      sclk_q = sclk;
      copi_q = copi;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one command and waits for it to be accepted. t is the cycle
  // of the accept edge; returns at the following negedge with valid dropped.
  task automatic send(input int which, input logic [6:0] a, input logic [7:0] d,
                      output int t);
    if (which == 0) begin
      bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
    end
    t = -1;
    for (int i = 0; i < 600; i++) begin
      #1;
      if ((which == 0 && bus.req0_ready) || (which == 1 && bus.req1_ready)) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req%0d got no ready, expected ready within 600 cycles", which);
    end else begin
      @(negedge clk);
    end
    if (which == 0) bus.req0_valid = 1'b0;
    else            bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      #1;
      if (!busy) break;
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: busy got 1, expected 0 within 600 cycles");
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL reset_ncs: got %b, expected 1", ncs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b, expected 0", sclk); end
    checks++; if (copi !== 1'b0) begin errors++; $display("FAIL reset_copi: got %b, expected 0", copi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", err); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, expected 0", dbg_state); end
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_no_valid: got %b%b, expected 00", bus.req0_ready, bus.req1_ready);
    end
  endtask

  task automatic test_single_write();
    int t, fall, dc0, fc0;
    dc0 = done_cnt;
    fc0 = frame_cnt;
    exp_q.push_back(16'h82A5);
    send(0, 7'd2, 8'hA5, t);
    #1;
    checks++; if (ncs !== 1'b0) begin errors++; $display("FAIL single_ncs_fall: got %b, expected 0 at T+1", ncs); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b, expected 1 at T+1", busy); end
    while (cyc < t + CLK_DIV) @(negedge clk);
    #1;
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL single_sclk_before_first_rise: got %b, expected 0", sclk); end
    @(negedge clk);
    #1;
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL single_first_sclk_rise: got %b, expected 1 at T+1+CLK_DIV", sclk); end
    fall = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        fall = cyc;
        break;
      end
    end
    checks++; if (fall - t != 35 * CLK_DIV) begin
      errors++; $display("FAIL single_busy_fall: got %0d cycles, expected %0d", fall - t, 35 * CLK_DIV);
    end
    checks++; if (done_cnt - dc0 != 1) begin errors++; $display("FAIL single_done_count: got %0d, expected 1", done_cnt - dc0); end
    checks++; if (frame_cnt - fc0 != 1) begin errors++; $display("FAIL single_frame_count: got %0d, expected 1", frame_cnt - fc0); end
    checks++; if (slave_regs[2] !== 8'hA5) begin errors++; $display("FAIL single_reg2: got %h, expected a5", slave_regs[2]); end
    checks++; if (slave_regs[0] !== 8'h00 || slave_regs[1] !== 8'h00 || slave_regs[3] !== 8'h00 || slave_regs[4] !== 8'h00) begin
      errors++; $display("FAIL single_other_regs: got %h %h %h %h, expected 00 00 00 00",
                         slave_regs[0], slave_regs[1], slave_regs[3], slave_regs[4]);
    end
  endtask

  task automatic test_tie();
    int order[2];
    int n, both_hi;
    bit done0, done1, pend0, pend1;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(16'h8011);
      exp_q.push_back(16'h8122);
      n = 0; both_hi = 0; done0 = 0; done1 = 0; pend0 = 0; pend1 = 0;
      order[0] = -1; order[1] = -1;
      if (r == 0) begin
        bus.req0_addr = 7'd0; bus.req0_data = 8'h11; bus.req0_valid = 1'b1;
        bus.req1_addr = 7'd1; bus.req1_data = 8'h22; bus.req1_valid = 1'b1;
      end else begin
        bus.req1_addr = 7'd1; bus.req1_data = 8'h22; bus.req1_valid = 1'b1;
        bus.req0_addr = 7'd0; bus.req0_data = 8'h11; bus.req0_valid = 1'b1;
      end
      for (int i = 0; i < 800; i++) begin
        #1;
        if (bus.req0_ready && bus.req1_ready) both_hi++;
        if (bus.req0_valid && bus.req0_ready && n < 2) begin order[n] = 0; n++; pend0 = 1; done0 = 1; end
        if (bus.req1_valid && bus.req1_ready && n < 2) begin order[n] = 1; n++; pend1 = 1; done1 = 1; end
        @(negedge clk);
        if (pend0) begin bus.req0_valid = 1'b0; pend0 = 0; end
        if (pend1) begin bus.req1_valid = 1'b0; pend1 = 0; end
        if (done0 && done1) break;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      checks++; if (order[0] !== 0) begin errors++; $display("FAIL tie%0d_first_grant: got req%0d, expected req0", r, order[0]); end
      checks++; if (order[1] !== 1) begin errors++; $display("FAIL tie%0d_second_grant: got req%0d, expected req1", r, order[1]); end
      checks++; if (both_hi != 0) begin errors++; $display("FAIL tie%0d_both_ready: got %0d cycles, expected 0", r, both_hi); end
      wait_idle();
    end
    checks++; if (slave_regs[0] !== 8'h11) begin errors++; $display("FAIL tie_reg0: got %h, expected 11", slave_regs[0]); end
    checks++; if (slave_regs[1] !== 8'h22) begin errors++; $display("FAIL tie_reg1: got %h, expected 22", slave_regs[1]); end
  endtask

  task automatic test_invalid_addr();
    int ec0, fc0;
    ec0 = err_cnt;
    fc0 = frame_cnt;
    exp_q.push_back(16'h835C);
    bus.req1_addr = 7'd5; bus.req1_data = 8'hFF; bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL invalid_ready: got %b, expected 1", bus.req1_ready); end
    @(negedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid_err_pulse: got %b, expected 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL invalid_busy: got %b, expected 0", busy); end
    checks++; if (ncs !== 1'b1 || sclk !== 1'b0 || copi !== 1'b0) begin
      errors++; $display("FAIL invalid_bus_idle: got ncs=%b sclk=%b copi=%b, expected 1 0 0", ncs, sclk, copi);
    end
    bus.req1_addr = 7'd3; bus.req1_data = 8'h5C;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL invalid_next_ready: got %b, expected 1", bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL invalid_err_width: got %b, expected 0", err); end
    checks++; if (ncs !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL invalid_next_frame_start: got ncs=%b busy=%b, expected 0 1", ncs, busy);
    end
    wait_idle();
    checks++; if (slave_regs[3] !== 8'h5C) begin errors++; $display("FAIL invalid_reg3: got %h, expected 5c", slave_regs[3]); end
    checks++; if (err_cnt - ec0 != 1) begin errors++; $display("FAIL invalid_err_count: got %0d, expected 1", err_cnt - ec0); end
    checks++; if (frame_cnt - fc0 != 1) begin errors++; $display("FAIL invalid_frame_count: got %0d, expected 1", frame_cnt - fc0); end
    checks++; if (slave_regs[4] !== 8'h00) begin errors++; $display("FAIL invalid_reg4: got %h, expected 00", slave_regs[4]); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    exp_q.push_back(16'h833C);
    exp_q.push_back(16'h844D);
    send(0, 7'd3, 8'h3C, t1);
    send(0, 7'd4, 8'h4D, t2);
    checks++; if (t2 - t1 != 35 * CLK_DIV) begin
      errors++; $display("FAIL b2b_accept_spacing: got %0d, expected %0d", t2 - t1, 35 * CLK_DIV);
    end
    wait_idle();
    checks++; if (last_gap < 2 * CLK_DIV) begin
      errors++; $display("FAIL b2b_ncs_gap: got %0d, expected >= %0d", last_gap, 2 * CLK_DIV);
    end
    checks++; if (slave_regs[3] !== 8'h3C) begin errors++; $display("FAIL b2b_reg3: got %h, expected 3c", slave_regs[3]); end
    checks++; if (slave_regs[4] !== 8'h4D) begin errors++; $display("FAIL b2b_reg4: got %h, expected 4d", slave_regs[4]); end
  endtask

  task automatic test_held_valid();
    int t0, t1;
    logic busy_at_ready;
    exp_q.push_back(16'h8177);
    exp_q.push_back(16'h8299);
    send(0, 7'd1, 8'h77, t0);
    repeat (40) @(negedge clk);
    bus.req1_addr = 7'd2; bus.req1_data = 8'h99; bus.req1_valid = 1'b1;
    t1 = -1;
    busy_at_ready = 1'bx;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (bus.req1_ready) begin
        t1 = cyc;
        busy_at_ready = busy;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    checks++; if (t1 - t0 != 35 * CLK_DIV) begin
      errors++; $display("FAIL held_ready_cycle: got %0d, expected %0d", t1 - t0, 35 * CLK_DIV);
    end
    checks++; if (busy_at_ready !== 1'b0) begin errors++; $display("FAIL held_ready_while_busy: got busy=%b, expected 0", busy_at_ready); end
    wait_idle();
    checks++; if (slave_regs[1] !== 8'h77) begin errors++; $display("FAIL held_reg1: got %h, expected 77", slave_regs[1]); end
    checks++; if (slave_regs[2] !== 8'h99) begin errors++; $display("FAIL held_reg2: got %h, expected 99", slave_regs[2]); end
  endtask

  task automatic test_reset_mid_frame();
    int t, dc0, fc0, n;
    dc0 = done_cnt;
    fc0 = frame_cnt;
    send(0, 7'd4, 8'hE1, t);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      #1;
      if (rises >= 9) break;
      n++;
    end
    checks++; if (rises != 9) begin errors++; $display("FAIL midreset_reach_bit9: got %0d rises, expected 9", rises); end
    rst_n = 1'b0;
    #1;
    checks++; if (ncs !== 1'b1 || sclk !== 1'b0 || copi !== 1'b0) begin
      errors++; $display("FAIL midreset_bus: got ncs=%b sclk=%b copi=%b, expected 1 0 0", ncs, sclk, copi);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL midreset_state: got %0d, expected 0", dbg_state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (done_cnt != dc0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses, expected 0", done_cnt - dc0); end
    checks++; if (frame_cnt != fc0) begin errors++; $display("FAIL midreset_no_frame: got %0d frames, expected 0", frame_cnt - fc0); end
    checks++; if (slave_regs[4] !== 8'h4D) begin errors++; $display("FAIL midreset_reg4: got %h, expected 4d", slave_regs[4]); end
    exp_q.push_back(16'h805A);
    send(1, 7'd0, 8'h5A, t);
    wait_idle();
    checks++; if (slave_regs[0] !== 8'h5A) begin errors++; $display("FAIL midreset_after_reg0: got %h, expected 5a", slave_regs[0]); end
    checks++; if (frame_cnt != fc0 + 1) begin errors++; $display("FAIL midreset_after_frames: got %0d, expected 1", frame_cnt - fc0); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_invalid_addr();
    test_back_to_back();
    test_held_valid();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    #1;
    checks++; if (copi_viol != 0) begin errors++; $display("FAIL copi_stability: got %0d violations, expected 0", copi_viol); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frames_missing: got %0d outstanding, expected 0", exp_q.size()); end
    checks++; if (done_cnt != frame_cnt) begin errors++; $display("FAIL done_vs_frames: got %0d done, expected %0d", done_cnt, frame_cnt); end
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL total_err_pulses: got %0d, expected 1", err_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation got no end, expected finish before 1000000 time units");
    $fatal(1);
  end

endmodule
